// File: rtl/bp_be_trace_ring_arbiter.sv
// ---------------------------------------------------------------------------
// bp_be_trace_ring_arbiter
//
// Shares one trace-ring output link between num_src_p commit-trace sources.
// Each source writes into a private FIFO. A round-robin arbiter moves FIFO
// heads into a single registered output stage. Every packet carries its
// source index as a tag. Sources do not honour backpressure, so a push into
// a full FIFO is dropped. Each drop increments a saturating per-source
// counter and sets a sticky per-source overflow flag.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   src_data_i     packed packets, source i in slice i
//   src_v_i        per-source packet valid
//   src_ready_o    per-source "FIFO not full" (advisory only)
//   enable_i       capture enable; when low, source inputs are ignored
//   clear_i        synchronous clear of drop counters and overflow flags
//   data_o         {src_id, payload} of the packet being presented
//   v_o            output valid
//   ready_i        downstream ready
//   drop_count_o   per-source saturating drop counters, packed
//   overflow_o     per-source sticky overflow flags
// ---------------------------------------------------------------------------
module bp_be_trace_ring_arbiter #(
   parameter int num_src_p          = 2,
   parameter int trace_ring_width_p = 129,
   parameter int fifo_els_p         = 4,
   parameter int cnt_width_p        = 16,
   localparam int src_id_width_lp   = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
   input  logic                                          clk_i,
   input  logic                                          reset_n_i,
   input  logic [num_src_p*trace_ring_width_p-1:0]       src_data_i,
   input  logic [num_src_p-1:0]                          src_v_i,
   output logic [num_src_p-1:0]                          src_ready_o,
   input  logic                                          enable_i,
   input  logic                                          clear_i,
   output logic [src_id_width_lp+trace_ring_width_p-1:0] data_o,
   output logic                                          v_o,
   input  logic                                          ready_i,
   output logic [num_src_p*cnt_width_p-1:0]              drop_count_o,
   output logic [num_src_p-1:0]                          overflow_o
);

   localparam int ptr_width_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
   localparam int occ_width_lp = $clog2(fifo_els_p + 1);
   localparam int out_width_lp = src_id_width_lp + trace_ring_width_p;

   logic [num_src_p-1:0]                         full_s;
   logic [num_src_p-1:0]                         nonempty_s;
   logic [num_src_p-1:0]                         push_s;
   logic [num_src_p-1:0]                         drop_s;
   logic [num_src_p-1:0]                         pop_s;
   logic [num_src_p-1:0][trace_ring_width_p-1:0] head_s;

   logic                       load_ok_s;
   logic                       grant_v_s;
   logic [src_id_width_lp-1:0] grant_idx_s;

   logic [out_width_lp-1:0]    data_q, data_d;
   logic                       v_q, v_d;
   logic [src_id_width_lp-1:0] ptr_q, ptr_d;

   // ------------------------------------------------------------------------
   // Per-source FIFO, drop counter and overflow flag
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < num_src_p; i++) begin : g_src
      logic [trace_ring_width_p-1:0] mem_q [fifo_els_p];
      logic [ptr_width_lp-1:0]       wr_ptr_q, wr_ptr_d;
      logic [ptr_width_lp-1:0]       rd_ptr_q, rd_ptr_d;
      logic [occ_width_lp-1:0]       occ_q, occ_d;
      logic [cnt_width_p-1:0]        cnt_q, cnt_d;
      logic                          ovf_q, ovf_d;

      // Full is decoded from registered occupancy only, so a pop in the
      // same cycle never makes room for a push.
      assign full_s[i]     = (occ_q == occ_width_lp'(fifo_els_p));
      assign nonempty_s[i] = (occ_q != {occ_width_lp{1'b0}});
      assign push_s[i]     = src_v_i[i] & enable_i & ~full_s[i];
      assign drop_s[i]     = src_v_i[i] & enable_i & full_s[i];
      assign pop_s[i]      = load_ok_s & grant_v_s & (grant_idx_s == src_id_width_lp'(i));
      assign head_s[i]     = mem_q[rd_ptr_q];

      assign src_ready_o[i]                                 = ~full_s[i];
      assign drop_count_o[i*cnt_width_p +: cnt_width_p]     = cnt_q;
      assign overflow_o[i]                                  = ovf_q;

      // Next-state for FIFO pointers, occupancy and drop bookkeeping
      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         occ_d    = occ_q;
         cnt_d    = cnt_q;
         ovf_d    = ovf_q;

         if (push_s[i]) begin
            wr_ptr_d = (wr_ptr_q == ptr_width_lp'(fifo_els_p - 1)) ? {ptr_width_lp{1'b0}}
                                                                   : wr_ptr_q + 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (pop_s[i]) begin
            rd_ptr_d = (rd_ptr_q == ptr_width_lp'(fifo_els_p - 1)) ? {ptr_width_lp{1'b0}}
                                                                   : rd_ptr_q + 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         case ({push_s[i], pop_s[i]})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
         endcase

         // Clear wins over a drop in the same cycle.
         if (clear_i) begin
            cnt_d = {cnt_width_p{1'b0}};
            ovf_d = 1'b0;
         end else if (drop_s[i]) begin
            cnt_d = (cnt_q == {cnt_width_p{1'b1}}) ? cnt_q : cnt_q + 1'b1;
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
         end
      end

      // FIFO control and statistics registers
      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            wr_ptr_q <= {ptr_width_lp{1'b0}};
            rd_ptr_q <= {ptr_width_lp{1'b0}};
            occ_q    <= {occ_width_lp{1'b0}};
            cnt_q    <= {cnt_width_p{1'b0}};
            ovf_q    <= 1'b0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
         end
      end

      // FIFO storage; contents are don't-care while occupancy is zero
      always_ff @(posedge clk_i) begin
         if (push_s[i]) begin
            mem_q[wr_ptr_q] <= src_data_i[i*trace_ring_width_p +: trace_ring_width_p];
         end
      end
   end

   // Round-robin search: candidates are visited farthest-first so the one
   // nearest to ptr_q+1 overrides earlier hits.
   always_comb begin
      logic [src_id_width_lp-1:0] cand_s;
      logic                       hit_s;
      load_ok_s   = ~v_q | ready_i;
      grant_v_s   = 1'b0;
      grant_idx_s = ptr_q;
      cand_s      = ptr_q;
      hit_s       = 1'b0;
      for (int off = num_src_p; off >= 1; off--) begin
         cand_s      = src_id_width_lp'((int'(ptr_q) + off) % num_src_p);
         hit_s       = nonempty_s[cand_s];
         grant_v_s   = grant_v_s | hit_s;
         grant_idx_s = hit_s ? cand_s : grant_idx_s;
      end
   end

   // Output stage next-state: load on grant, go idle when nothing to send
   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      ptr_d  = ptr_q;
      if (load_ok_s) begin
         if (grant_v_s) begin
            v_d    = 1'b1;
            data_d = {grant_idx_s, head_s[grant_idx_s]};
            ptr_d  = grant_idx_s;
         end else begin
            v_d    = 1'b0;
         end
      end else begin
         v_d = v_q;
      end
   end

   // Output stage and round-robin pointer registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_q    <= 1'b0;
         data_q <= {out_width_lp{1'b0}};
         ptr_q  <= src_id_width_lp'(num_src_p - 1);
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
         ptr_q  <= ptr_d;
      end
   end

   assign v_o    = v_q;
   assign data_o = data_q;

endmodule

// File: doc/bp_be_trace_ring_arbiter.md
Name: bp_be_trace_ring_arbiter

Overview:
- Shares one trace-ring output link between num_src_p commit-trace generators, one per core or hart.
- Each source has a private FIFO. A round-robin arbiter moves entries into a registered output stage. Each packet is tagged with its source index.
- Trace generators assert valid without honouring backpressure. The block therefore counts dropped packets per source and keeps a sticky overflow flag per source.

Parameters:
- num_src_p, 2, number of trace sources (>=2).
- trace_ring_width_p, 129, payload width of one trace packet.
- fifo_els_p, 4, depth of each per-source FIFO (>=2).
- cnt_width_p, 16, width of each saturating drop counter.
- src_id_width_lp (local), max(1, clog2(num_src_p)), width of the source tag.

Ports:
- clk_i, in, 1, clock; all state changes on the rising edge.
- reset_n_i, in, 1, asynchronous active-low reset.
- src_data_i, in, num_src_p*trace_ring_width_p, packed packets; source i occupies slice i.
- src_v_i, in, num_src_p, per-source packet valid.
- src_ready_o, out, num_src_p, per-source FIFO not full (advisory only).
- enable_i, in, 1, capture enable; when low, source inputs are ignored.
- clear_i, in, 1, synchronous clear of drop counters and overflow flags.
- data_o, out, src_id_width_lp+trace_ring_width_p, {src_id, payload}.
- v_o, out, 1, output valid.
- ready_i, in, 1, downstream ready.
- drop_count_o, out, num_src_p*cnt_width_p, per-source saturating drop counts.
- overflow_o, out, num_src_p, per-source sticky overflow flags.

Behaviour:
- Reset (reset_n_i low, takes effect immediately, no clock edge needed):
  - All FIFOs empty; v_o=0; data_o=0.
  - drop_count_o=0; overflow_o=0.
  - RR pointer = num_src_p-1, so source 0 has first priority.
  - src_ready_o=all ones once reset is released.
- src_ready_o[i] = ~full[i], decoded from the registered occupancy only. It has no combinational dependence on pops.
- Push, source i, at an edge:
  - If src_v_i[i] & enable_i & ~full[i]: write src_data_i slice i to the FIFO tail.
  - If src_v_i[i] & enable_i & full[i]: drop the packet; drop_count[i] += 1, saturating at all-ones; overflow[i] <= 1.
  - A full FIFO drops even if it is popped in the same cycle. There is no same-cycle pop forwarding.
  - If enable_i is low: no push and no drop counting.
- Output stage: one register holding {data_o, v_o}.
  - load_ok = ~v_o | ready_i.
  - When load_ok, grant the first non-empty source searching from pointer+1 with wrap-around (modulo num_src_p).
  - On a grant: pop that FIFO head, load {grant_idx, head} into the register, set v_o=1, pointer <= grant_idx.
  - When load_ok and no source is non-empty: v_o <= 0; data_o holds its previous value; pointer unchanged.
  - While v_o & ~ready_i, data_o and v_o are held bit-stable.
  - Transfer occurs on an edge where v_o & ready_i.
- Latency: a packet pushed at edge k appears on v_o/data_o after edge k+1 at the earliest. With continuous ready_i, throughput is 1 packet/cycle.
- Ordering: per-source FIFO order is preserved. Interleaving between sources is strictly round-robin among non-empty FIFOs.
- clear_i is synchronous, takes priority over drops in the same cycle (counter becomes 0, overflow becomes 0), and does not flush FIFOs or the output stage.
- FIFO pointers wrap modulo fifo_els_p. Occupancy counter width is clog2(fifo_els_p+1).
- Reset asserted mid-transfer discards all buffered packets. No partial state survives.

Test Plan:
- Single source, num_src_p=2, ready_i=1: src0 pushes 0x1A5 at edge 1 -> after edge 2, v_o=1, data_o={1'b0,0x1A5}; after edge 3, v_o=0.
- Both sources valid every cycle, ready_i=1, enable_i=1 -> output tags alternate 0,1,0,1 starting with 0; no drops; overflow_o=0.
- Backpressure: ready_i=0, fifo_els_p=4, src0 pushes P1..P6 at edges 1..6:
  - data_o holds P1 stable; P6 dropped; drop_count[0]=1; overflow_o[0]=1; src_ready_o[0]=0 after edge 5.
  - Then ready_i=1 -> P1..P5 emerge on consecutive cycles.
- Saturation, cnt_width_p=4: FIFO full, 20 further pushes -> drop_count[0]=15, no wrap. Then clear_i for one cycle concurrent with another drop -> count=0, overflow_o[0]=0.
- enable_i=0 with src_v_i=2'b11 for 8 cycles -> no pushes, counters unchanged, v_o stays 0.
- Drive reset_n_i low between clock edges while v_o=1 and FIFOs are non-empty -> v_o=0 and data_o=0 immediately. After release, the first grant goes to source 0 and no stale packet is emitted.
